// File: rtl/mov_pipe_pkg.sv
// rtl/mov_pipe_pkg.sv - move opcodes, flag width and the shared move result function
package mov_pkg;

    typedef enum logic [1:0] {
        MOV_OP_MOV  = 2'b00,
        MOV_OP_MVN  = 2'b01,
        MOV_OP_MOVZ = 2'b10,
        MOV_OP_MOVS = 2'b11
    } mov_op_e;

    localparam int MOV_FLAG_W = 2;
    localparam int MOV_MAX_W  = 64;

    // Bit-serial form so a single function serves any WIDTH/EXT_W up to MOV_MAX_W.
    function automatic logic [MOV_MAX_W-1:0] mov_calc(input mov_op_e op,
                                                      input logic [MOV_MAX_W-1:0] a,
                                                      input int width,
                                                      input int ext_w);
        logic [MOV_MAX_W-1:0] r;
        logic                 sgn;
        r   = '0;
        sgn = a[ext_w-1];
        for (int i = 0; i < MOV_MAX_W; i++) begin
            if (i < width) begin
                case (op)
                    MOV_OP_MOV:  r[i] = a[i];
                    MOV_OP_MVN:  r[i] = ~a[i];
                    MOV_OP_MOVZ: r[i] = (i < ext_w) ? a[i] : 1'b0;
                    MOV_OP_MOVS: r[i] = (i < ext_w) ? a[i] : sgn;
                    default:     r[i] = 1'b0;
                endcase
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mov_pipe_if.sv
// rtl/mov_pipe_if.sv - operand/result handshake bundle; out_flags exists only with MOV_FLAGS_EN
interface mov_pipe_if
    import mov_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
);
    logic                         in_valid;
    logic                         in_ready;
    mov_op_e                      in_op;
    logic [WIDTH-1:0]             in_a;
    logic                         out_valid;
    logic                         out_ready;
    logic [WIDTH-1:0]             out_data;
    logic [$clog2(DEPTH+1)-1:0]   count;
`ifdef MOV_FLAGS_EN
    logic [MOV_FLAG_W-1:0]        out_flags;
`endif

    modport master (
        output in_valid, in_op, in_a, out_ready,
        input  in_ready, out_valid, out_data, count
`ifdef MOV_FLAGS_EN
        , input out_flags
`endif
    );

    modport slave (
        input  in_valid, in_op, in_a, out_ready,
        output in_ready, out_valid, out_data, count
`ifdef MOV_FLAGS_EN
        , output out_flags
`endif
    );

endinterface

// File: rtl/mov_pipe_fifo.sv
// rtl/mov_pipe_fifo.sv - generic synchronous FIFO with zeroed head when empty
module mov_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [W-1:0]               data_in,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [W-1:0]               head
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [CW-1:0] cnt;
    logic          do_push;
    logic          do_pop;

    assign full    = (cnt == CW'(DEPTH));
    assign empty   = (cnt == '0);
    assign do_pop  = pop & ~empty;
    // A push into a full FIFO is legal only when the head leaves in the same cycle.
    assign do_push = push & (~full | do_pop);
    assign count   = cnt;
    assign head    = empty ? '0 : mem[rptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            if (do_push && !do_pop)      cnt <= cnt + 1'b1;
            else if (do_pop && !do_push) cnt <= cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= data_in;
    end

endmodule

// File: rtl/mov_pipe.sv
// rtl/mov_pipe.sv - registered MOV/MVN/MOVZ/MOVS unit with result FIFO; MOV_FLAGS_EN adds {N,Z} flags
module mov_pipe
    import mov_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    parameter int EXT_W = 16
) (
    input  logic    clk,
    input  logic    rst_n,
    mov_pipe_if.slave bus
);
`ifdef MOV_FLAGS_EN
    localparam int FW = WIDTH + MOV_FLAG_W;
`else
    localparam int FW = WIDTH;
`endif

    logic [MOV_MAX_W-1:0] a_ext;
    logic [MOV_MAX_W-1:0] calc_full;
    logic [WIDTH-1:0]     result;
    logic [FW-1:0]        entry;
    logic [FW-1:0]        head;
    logic                 full;
    logic                 empty;
    logic                 push;
    logic                 pop;

    always_comb begin
        a_ext             = '0;
        a_ext[WIDTH-1:0]  = bus.in_a;
    end

    assign calc_full = mov_calc(bus.in_op, a_ext, WIDTH, EXT_W);
    assign result    = calc_full[WIDTH-1:0];

    generate
        if (WIDTH < MOV_MAX_W) begin : g_unused_hi
            logic unused_hi;
            assign unused_hi = ^calc_full[MOV_MAX_W-1:WIDTH];
        end
    endgenerate

`ifdef MOV_FLAGS_EN
    assign entry         = {result[WIDTH-1], (result == '0), result};
    assign bus.out_flags = head[FW-1:WIDTH];
`else
    assign entry         = result;
`endif

    assign bus.in_ready  = ~full | bus.out_ready;
    assign bus.out_valid = ~empty;
    assign bus.out_data  = head[WIDTH-1:0];
    assign push          = bus.in_valid & bus.in_ready;
    assign pop           = ~empty & bus.out_ready;

    mov_fifo #(
        .W     (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push),
        .pop     (pop),
        .data_in (entry),
        .full    (full),
        .empty   (empty),
        .count   (bus.count),
        .head    (head)
    );

endmodule

// File: tb/tb_mov_pipe.sv
// tb/tb_mov_pipe.sv - scoreboard bench for mov_pipe; flag checks compiled with MOV_FLAGS_EN
module tb_mov_pipe;
    import mov_pkg::*;

    localparam int WIDTH = 32;
    localparam int DEPTH = 2;
    localparam int EXT_W = 16;

    logic clk;
    logic rst_n;
    int   tests_run;
    int   fails;

    logic [WIDTH-1:0] exp_q [$];
`ifdef MOV_FLAGS_EN
    logic [1:0]       exp_fq [$];
`endif

    mov_pipe_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    mov_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .EXT_W(EXT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] model(input mov_op_e op, input logic [WIDTH-1:0] a);
        logic signed [WIDTH-1:0] t;
        case (op)
            MOV_OP_MOV:  return a;
            MOV_OP_MVN:  return ~a;
            MOV_OP_MOVZ: return a & ((WIDTH'(1) << EXT_W) - 1'b1);
            default: begin
                t = a << (WIDTH - EXT_W);
                t = t >>> (WIDTH - EXT_W);
                return t;
            end
        endcase
    endfunction

    // Handshakes are sampled mid-cycle, so each one here completes at the following rising edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.out_valid && bus.out_ready) begin
                logic [WIDTH-1:0] e;
                tests_run++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL sb_unexpected: got %h, required no output", bus.out_data);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.out_data !== e) begin
                        fails++;
                        $display("FAIL sb_data: got %h, required %h", bus.out_data, e);
                    end
`ifdef MOV_FLAGS_EN
                    begin
                        logic [1:0] ef;
                        ef = exp_fq.pop_front();
                        tests_run++;
                        if (bus.out_flags !== ef) begin
                            fails++;
                            $display("FAIL sb_flags: got %b, required %b", bus.out_flags, ef);
                        end
                    end
`endif
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                logic [WIDTH-1:0] r;
                r = model(bus.in_op, bus.in_a);
                exp_q.push_back(r);
`ifdef MOV_FLAGS_EN
                exp_fq.push_back({r[WIDTH-1], (r == '0)});
`endif
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input mov_op_e op, input logic [WIDTH-1:0] a);
        bus.in_valid = v;
        bus.in_op    = op;
        bus.in_a     = a;
    endtask

    task automatic sb_clear();
        exp_q.delete();
`ifdef MOV_FLAGS_EN
        exp_fq.delete();
`endif
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.out_ready = 1'b0;
        drive(1'b0, MOV_OP_MOV, '0);
        #12;
        tests_run += 4;
        if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b, required 0", bus.out_valid); end
        if (bus.count !== 2'd0) begin fails++; $display("FAIL reset_count: got %0d, required 0", bus.count); end
        if (bus.out_data !== 32'h0) begin fails++; $display("FAIL reset_data: got %h, required 0", bus.out_data); end
        if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b, required 1", bus.in_ready); end
`ifdef MOV_FLAGS_EN
        tests_run++;
        if (bus.out_flags !== 2'b00) begin fails++; $display("FAIL reset_flags: got %b, required 00", bus.out_flags); end
`endif
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_mov();
        bus.out_ready = 1'b1;
        drive(1'b1, MOV_OP_MOV, 32'hDEADBEEF);
        tick();
        drive(1'b0, MOV_OP_MOV, '0);
        tests_run += 3;
        if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL mov_valid: got %b, required 1", bus.out_valid); end
        if (bus.out_data !== 32'hDEADBEEF) begin fails++; $display("FAIL mov_data: got %h, required deadbeef", bus.out_data); end
        if (bus.count !== 2'd1) begin fails++; $display("FAIL mov_count: got %0d, required 1", bus.count); end
        tick();
        tests_run++;
        if (bus.count !== 2'd0) begin fails++; $display("FAIL mov_drain: got %0d, required 0", bus.count); end
    endtask

    task automatic test_modes();
        mov_op_e          ops  [4];
        logic [WIDTH-1:0] want [4];
        ops  = '{MOV_OP_MOV, MOV_OP_MVN, MOV_OP_MOVZ, MOV_OP_MOVS};
        want = '{32'h0000_8001, 32'hFFFF_7FFE, 32'h0000_8001, 32'hFFFF_8001};
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, ops[i], 32'h0000_8001);
            tick();
            drive(1'b0, MOV_OP_MOV, '0);
            tests_run++;
            if (bus.out_data !== want[i]) begin
                fails++;
                $display("FAIL mode_%0d: got %h, required %h", i, bus.out_data, want[i]);
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        bus.out_ready = 1'b0;
        drive(1'b1, MOV_OP_MOV, 32'h1111_1111);
        tick();
        drive(1'b1, MOV_OP_MVN, 32'h2222_2222);
        tick();
        drive(1'b1, MOV_OP_MOVZ, 32'h3333_C333);
        tests_run += 2;
        if (bus.count !== 2'd2) begin fails++; $display("FAIL bp_count: got %0d, required 2", bus.count); end
        if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL bp_ready_low: got %b, required 0", bus.in_ready); end
        tick();
        tests_run++;
        if (bus.count !== 2'd2) begin fails++; $display("FAIL bp_hold: got %0d, required 2", bus.count); end
        bus.out_ready = 1'b1;
        #1;
        tests_run++;
        if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL bp_ready_high: got %b, required 1", bus.in_ready); end
        tick();
        drive(1'b0, MOV_OP_MOV, '0);
        tests_run++;
        if (bus.count !== 2'd2) begin fails++; $display("FAIL bp_swap_count: got %0d, required 2", bus.count); end
        tick();
        tick();
        tests_run++;
        if (bus.count !== 2'd0) begin fails++; $display("FAIL bp_drain: got %0d, required 0", bus.count); end
    endtask

    task automatic test_back_to_back();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, mov_op_e'($urandom_range(0, 3)), $urandom);
            tick();
        end
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, mov_op_e'($urandom_range(0, 3)), $urandom);
            tick();
            tests_run++;
            if (bus.count !== 2'd2) begin
                fails++;
                $display("FAIL b2b_count_%0d: got %0d, required 2", i, bus.count);
            end
        end
        drive(1'b0, MOV_OP_MOV, '0);
        tick();
        tick();
        tests_run++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL b2b_leftover: got %0d pending, required 0", exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        bus.out_ready = 1'b0;
        drive(1'b1, MOV_OP_MVN, 32'hA5A5_0000);
        tick();
        drive(1'b1, MOV_OP_MOV, 32'h0BAD_F00D);
        tick();
        drive(1'b0, MOV_OP_MOV, '0);
        tests_run++;
        if (bus.count !== 2'd2) begin fails++; $display("FAIL rm_pre_count: got %0d, required 2", bus.count); end
        #2;
        rst_n = 1'b0;
        #1;
        tests_run += 3;
        if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL rm_valid: got %b, required 0", bus.out_valid); end
        if (bus.count !== 2'd0) begin fails++; $display("FAIL rm_count: got %0d, required 0", bus.count); end
        if (bus.out_data !== 32'h0) begin fails++; $display("FAIL rm_data: got %h, required 0", bus.out_data); end
        sb_clear();
        tick();
        rst_n         = 1'b1;
        bus.out_ready = 1'b1;
        drive(1'b1, MOV_OP_MOVS, 32'h0000_8001);
        tick();
        drive(1'b0, MOV_OP_MOV, '0);
        tests_run++;
        if (bus.out_data !== 32'hFFFF_8001) begin fails++; $display("FAIL rm_post: got %h, required ffff8001", bus.out_data); end
        tick();
    endtask

`ifdef MOV_FLAGS_EN
    task automatic test_flags();
        mov_op_e          ops  [3];
        logic [WIDTH-1:0] as   [3];
        logic [1:0]       want [3];
        ops  = '{MOV_OP_MOV, MOV_OP_MVN, MOV_OP_MOV};
        as   = '{32'd0, 32'd0, 32'd5};
        want = '{2'b01, 2'b10, 2'b00};
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, ops[i], as[i]);
            tick();
            drive(1'b0, MOV_OP_MOV, '0);
            tests_run++;
            if (bus.out_flags !== want[i]) begin
                fails++;
                $display("FAIL flags_%0d: got %b, required %b", i, bus.out_flags, want[i]);
            end
            tick();
        end
    endtask
`endif

    initial begin
        tests_run = 0;
        fails     = 0;
        test_reset();
        test_mov();
        test_modes();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
`ifdef MOV_FLAGS_EN
        test_flags();
`endif
        tests_run++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL sb_final: got %0d pending, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
